// File: rtl/reset_sequencer.sv
// Reset sequencer: holds all channel resets after power-on, waits for a
// filtered PLL lock, then releases the channels one at a time with a fixed
// stagger. Lock loss or a software request restarts the appropriate phase,
// and the cause of the last restart(s) is kept in a sticky register.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// HOLD       | power-on / software hold, all channels in reset
// WAIT_LOCK  | waiting for LOCK_FILT consecutive lock cycles
// RELEASE    | releasing channels 0..NUM_OUT-1, one every STAGGER cycles
// RUN        | all channels released, all_ready high
module reset_sequencer #(
   parameter int NUM_OUT     = 4,
   parameter int POR_CYCLES  = 255,
   parameter int LOCK_FILT   = 4,
   parameter int STAGGER     = 16,
   parameter int SYNC_STAGES = 2,
   parameter int USE_LOCK    = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               pll_lock,
   input  logic               sw_reset_req,
   input  logic               cause_clr,
   output logic [NUM_OUT-1:0] rst_out,
   output logic               all_ready,
   output logic [1:0]         state,
   output logic [2:0]         rst_cause
);

   typedef enum logic [1:0] {
      ST_HOLD      = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_RELEASE   = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   localparam int              CH_W      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
   localparam logic [15:0]     HOLD_LAST = 16'(POR_CYCLES - 1);
   localparam logic [7:0]      FILT_LAST = 8'(LOCK_FILT - 1);
   localparam logic [7:0]      STG_LAST  = 8'(STAGGER - 1);
   localparam logic [CH_W-1:0] CH_LAST   = CH_W'(NUM_OUT - 1);
   localparam logic [CH_W-1:0] CH_ONE    = CH_W'(1);

   state_t                 state_q, state_d;
   logic [15:0]            hold_q, hold_d;
   logic [7:0]             filt_q, filt_d;
   logic [7:0]             stg_q, stg_d;
   logic [CH_W-1:0]        ch_q, ch_d;
   logic [NUM_OUT-1:0]     rst_q, rst_d;
   logic [2:0]             cause_q, cause_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lock_s;
   logic                   sw_evt;
   logic                   lock_evt;

   // pll_lock is asynchronous to clk; plain shift-register synchroniser
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
      end
   end

   generate
      if (USE_LOCK != 0) begin : g_lock
         assign lock_s = sync_q[SYNC_STAGES-1];
      end else begin : g_no_lock
         assign lock_s = 1'b1;
      end
   endgenerate

   // Software request is meaningless while already holding; lock loss only
   // matters once channels have started to come out of reset.
   assign sw_evt   = sw_reset_req && (state_q != ST_HOLD);
   assign lock_evt = !lock_s && ((state_q == ST_RELEASE) || (state_q == ST_RUN));

   // State, counters, channel resets and cause register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_HOLD;
         hold_q  <= '0;
         filt_q  <= '0;
         stg_q   <= '0;
         ch_q    <= '0;
         rst_q   <= '1;
         cause_q <= 3'b001;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         filt_q  <= filt_d;
         stg_q   <= stg_d;
         ch_q    <= ch_d;
         rst_q   <= rst_d;
         cause_q <= cause_d;
      end
   end

   // Next-state logic; software request outranks lock loss
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      filt_d  = filt_q;
      stg_d   = stg_q;
      ch_d    = ch_q;
      rst_d   = rst_q;

      if (sw_evt) begin
         state_d = ST_HOLD;
         hold_d  = '0;
         filt_d  = '0;
         stg_d   = '0;
         ch_d    = '0;
         rst_d   = '1;
      end else if (lock_evt) begin
         state_d = ST_WAIT_LOCK;
         filt_d  = '0;
         stg_d   = '0;
         ch_d    = '0;
         rst_d   = '1;
      end else begin
         case (state_q)
            ST_HOLD: begin
               rst_d = '1;
               if (hold_q == HOLD_LAST) begin
                  state_d = ST_WAIT_LOCK;
                  hold_d  = '0;
                  filt_d  = '0;
               end else begin
                  hold_d = hold_q + 16'd1;
               end
            end
            ST_WAIT_LOCK: begin
               rst_d = '1;
               if (!lock_s) begin
                  filt_d = '0;
               end else if (filt_q == FILT_LAST) begin
                  state_d = ST_RELEASE;
                  filt_d  = '0;
                  stg_d   = '0;
                  ch_d    = '0;
               end else begin
                  filt_d = filt_q + 8'd1;
               end
            end
            ST_RELEASE: begin
               if (stg_q == STG_LAST) begin
                  stg_d = '0;
                  for (int k = 0; k < NUM_OUT; k++) begin
                     if (ch_q == CH_W'(k)) begin
                        rst_d[k] = 1'b0;
                     end
                  end
                  if (ch_q == CH_LAST) begin
                     state_d = ST_RUN;
                  end else begin
                     ch_d = ch_q + CH_ONE;
                  end
               end else begin
                  stg_d = stg_q + 8'd1;
               end
            end
            ST_RUN: begin
               rst_d = '0;
            end
            default: begin
               state_d = ST_HOLD;
               hold_d  = '0;
               rst_d   = '1;
            end
         endcase
      end
   end

   // Sticky causes: a clear drops everything, a same-cycle event re-sets its bit
   always_comb begin
      cause_d = cause_clr ? 3'b000 : cause_q;
      if (sw_evt) begin
         cause_d[2] = 1'b1;
      end
      if (lock_evt) begin
         cause_d[1] = 1'b1;
      end
   end

   assign rst_out   = rst_q;
   assign all_ready = (state_q == ST_RUN);
   assign state     = state_q;
   assign rst_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default-parameter instance and a minimal
// instance (one channel, no lock input). Expected output snapshots are
// queued with the cycle they apply to and compared on the falling edge.
module tb_reset_sequencer;

   logic       clk;
   logic       reset_n;
   logic       pll_lock;
   logic       sw_reset_req;
   logic       cause_clr;
   logic [3:0] rst_out;
   logic       all_ready;
   logic [1:0] state;
   logic [2:0] rst_cause;

   logic       pll_lock2;
   logic       sw_reset_req2;
   logic       cause_clr2;
   logic [0:0] rst_out2;
   logic       all_ready2;
   logic [1:0] state2;
   logic [2:0] rst_cause2;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      int         cyc;
      bit         w;
      logic [3:0] rst;
      logic [1:0] st;
      logic       rdy;
      logic [2:0] cause;
      string      tag;
   } exp_t;

   exp_t sb[$];

   reset_sequencer dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .pll_lock     (pll_lock),
      .sw_reset_req (sw_reset_req),
      .cause_clr    (cause_clr),
      .rst_out      (rst_out),
      .all_ready    (all_ready),
      .state        (state),
      .rst_cause    (rst_cause)
   );

   reset_sequencer #(
      .NUM_OUT    (1),
      .POR_CYCLES (1),
      .STAGGER    (1),
      .USE_LOCK   (0)
   ) dut2 (
      .clk          (clk),
      .reset_n      (reset_n),
      .pll_lock     (pll_lock2),
      .sw_reset_req (sw_reset_req2),
      .cause_clr    (cause_clr2),
      .rst_out      (rst_out2),
      .all_ready    (all_ready2),
      .state        (state2),
      .rst_cause    (rst_cause2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // cycle index: 1 at the first rising edge after reset_n goes high
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic void expect_at(input int c, input bit w, input logic [3:0] r,
                                     input logic [1:0] s, input logic rdy,
                                     input logic [2:0] ca, input string tag);
      exp_t e;
      e.cyc = c; e.w = w; e.rst = r; e.st = s; e.rdy = rdy; e.cause = ca; e.tag = tag;
      sb.push_back(e);
   endfunction

   // Scoreboard: pop every entry due this cycle and compare
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc != cyc) begin
               chk({e.tag, "_missed"}, cyc, e.cyc);
            end else if (!e.w) begin
               chk({e.tag, "_rst"},   {28'd0, rst_out},   {28'd0, e.rst});
               chk({e.tag, "_state"}, {30'd0, state},     {30'd0, e.st});
               chk({e.tag, "_rdy"},   {31'd0, all_ready}, {31'd0, e.rdy});
               chk({e.tag, "_cause"}, {29'd0, rst_cause}, {29'd0, e.cause});
            end else begin
               chk({e.tag, "_rst"},   {31'd0, rst_out2},   {28'd0, e.rst});
               chk({e.tag, "_state"}, {30'd0, state2},     {30'd0, e.st});
               chk({e.tag, "_rdy"},   {31'd0, all_ready2}, {31'd0, e.rdy});
               chk({e.tag, "_cause"}, {29'd0, rst_cause2}, {29'd0, e.cause});
            end
         end
      end
   end

   task automatic go_to(input int n);
      int guard = 0;
      while (cyc < n) begin
         @(posedge clk);
         #1;
         guard++;
         if (guard > 5000) begin
            $display("FAIL go_to_timeout observed=%0d required=%0d", cyc, n);
            $fatal(1, "cycle wait expired");
         end
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      chk("drain_left", sb.size(), 0);
   endtask

   task automatic check_in_reset(input string tag);
      chk({tag, "_rst"},    {28'd0, rst_out},    32'hF);
      chk({tag, "_state"},  {30'd0, state},      32'd0);
      chk({tag, "_rdy"},    {31'd0, all_ready},  32'd0);
      chk({tag, "_cause"},  {29'd0, rst_cause},  32'd1);
      chk({tag, "_rst2"},   {31'd0, rst_out2},   32'd1);
      chk({tag, "_state2"}, {30'd0, state2},     32'd0);
   endtask

   // Power-on sequence expectations for both instances, relative to release
   task automatic push_por_sequence(input string p);
      expect_at(1,   0, 4'hF, 2'd0, 1'b0, 3'b001, {p, "hold_c1"});
      expect_at(1,   1, 4'h1, 2'd1, 1'b0, 3'b001, {p, "m_wait_c1"});
      expect_at(4,   1, 4'h1, 2'd1, 1'b0, 3'b001, {p, "m_wait_c4"});
      expect_at(5,   1, 4'h1, 2'd2, 1'b0, 3'b001, {p, "m_rel_c5"});
      expect_at(6,   1, 4'h0, 2'd3, 1'b1, 3'b001, {p, "m_run_c6"});
      expect_at(254, 0, 4'hF, 2'd0, 1'b0, 3'b001, {p, "hold_c254"});
      expect_at(255, 0, 4'hF, 2'd1, 1'b0, 3'b001, {p, "wait_c255"});
      expect_at(258, 0, 4'hF, 2'd1, 1'b0, 3'b001, {p, "wait_c258"});
      expect_at(259, 0, 4'hF, 2'd2, 1'b0, 3'b001, {p, "rel_c259"});
      expect_at(274, 0, 4'hF, 2'd2, 1'b0, 3'b001, {p, "rel_c274"});
      expect_at(275, 0, 4'hE, 2'd2, 1'b0, 3'b001, {p, "ch0_c275"});
      expect_at(290, 0, 4'hE, 2'd2, 1'b0, 3'b001, {p, "ch0_c290"});
      expect_at(291, 0, 4'hC, 2'd2, 1'b0, 3'b001, {p, "ch1_c291"});
      expect_at(307, 0, 4'h8, 2'd2, 1'b0, 3'b001, {p, "ch2_c307"});
      expect_at(322, 0, 4'h8, 2'd2, 1'b0, 3'b001, {p, "ch2_c322"});
      expect_at(323, 0, 4'h0, 2'd3, 1'b1, 3'b001, {p, "run_c323"});
   endtask

   initial begin
      reset_n       = 1'b0;
      pll_lock      = 1'b1;
      sw_reset_req  = 1'b0;
      cause_clr     = 1'b0;
      pll_lock2     = 1'b0;
      sw_reset_req2 = 1'b0;
      cause_clr2    = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check_in_reset("por");
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // power-on release with lock held high
      push_por_sequence("");

      // one-cycle lock drop in RUN, then relock and full re-release
      expect_at(332, 0, 4'h0, 2'd3, 1'b1, 3'b001, "loss_c332");
      expect_at(333, 0, 4'hF, 2'd1, 1'b0, 3'b011, "loss_c333");
      expect_at(336, 0, 4'hF, 2'd1, 1'b0, 3'b011, "relock_c336");
      expect_at(337, 0, 4'hF, 2'd2, 1'b0, 3'b011, "relock_c337");
      expect_at(353, 0, 4'hE, 2'd2, 1'b0, 3'b011, "relock_ch0");
      expect_at(400, 0, 4'h8, 2'd2, 1'b0, 3'b011, "relock_c400");
      expect_at(401, 0, 4'h0, 2'd3, 1'b1, 3'b011, "relock_run");
      go_to(330);
      pll_lock = 1'b0;
      go_to(331);
      pll_lock = 1'b1;

      // lock chattering every 3 cycles never satisfies the filter
      expect_at(413, 0, 4'hF, 2'd1, 1'b0, 3'b011, "chat_c413");
      expect_at(420, 0, 4'hF, 2'd1, 1'b0, 3'b011, "chat_c420");
      expect_at(430, 0, 4'hF, 2'd1, 1'b0, 3'b011, "chat_c430");
      expect_at(440, 0, 4'hF, 2'd1, 1'b0, 3'b011, "chat_c440");
      expect_at(448, 0, 4'hF, 2'd1, 1'b0, 3'b011, "chat_c448");
      expect_at(449, 0, 4'hF, 2'd2, 1'b0, 3'b011, "chat_rel");
      expect_at(513, 0, 4'h0, 2'd3, 1'b1, 3'b011, "chat_run");
      go_to(410);
      pll_lock = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         go_to(410 + 3 * i);
         pll_lock = ~pll_lock;
      end
      go_to(443);
      pll_lock = 1'b1;

      // software request coinciding with synchronised lock loss, then clear
      expect_at(522,  0, 4'h0, 2'd3, 1'b1, 3'b011, "both_c522");
      expect_at(523,  0, 4'hF, 2'd0, 1'b0, 3'b111, "both_c523");
      expect_at(530,  0, 4'hF, 2'd0, 1'b0, 3'b111, "clr_c530");
      expect_at(531,  0, 4'hF, 2'd0, 1'b0, 3'b000, "clr_c531");
      expect_at(777,  0, 4'hF, 2'd0, 1'b0, 3'b000, "hold2_c777");
      expect_at(778,  0, 4'hF, 2'd1, 1'b0, 3'b000, "hold2_c778");
      expect_at(781,  0, 4'hF, 2'd0, 1'b0, 3'b100, "swclr_c781");
      expect_at(791,  0, 4'hF, 2'd0, 1'b0, 3'b100, "swhold_c791");
      expect_at(1035, 0, 4'hF, 2'd0, 1'b0, 3'b100, "hold3_c1035");
      expect_at(1036, 0, 4'hF, 2'd1, 1'b0, 3'b100, "hold3_c1036");
      expect_at(1036, 1, 4'h0, 2'd3, 1'b1, 3'b001, "m_run_c1036");
      expect_at(1040, 0, 4'hF, 2'd2, 1'b0, 3'b100, "rel3_c1040");
      expect_at(1045, 0, 4'hF, 2'd2, 1'b0, 3'b100, "rel3_c1045");
      go_to(520);
      pll_lock = 1'b0;
      go_to(522);
      sw_reset_req = 1'b1;
      go_to(523);
      sw_reset_req = 1'b0;
      go_to(525);
      pll_lock = 1'b1;
      go_to(530);
      cause_clr = 1'b1;
      go_to(531);
      cause_clr = 1'b0;
      go_to(780);
      sw_reset_req = 1'b1;
      cause_clr    = 1'b1;
      go_to(781);
      sw_reset_req = 1'b0;
      cause_clr    = 1'b0;
      go_to(790);
      sw_reset_req = 1'b1;
      go_to(791);
      sw_reset_req = 1'b0;
      drain();

      // short reset glitch mid-RELEASE: immediate reset, then a fresh sequence
      go_to(1050);
      chk("pre_glitch_state", {30'd0, state}, 32'd2);
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check_in_reset("glitch");
      #1;
      reset_n = 1'b1;
      push_por_sequence("re_");
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_OUT, default 4: number of sequenced reset channels (1..16).
REQ-002 Parameter POR_CYCLES, default 255: HOLD duration in clk cycles (1..65535).
REQ-003 Parameter LOCK_FILT, default 4: consecutive synchronised lock-high cycles required (1..255).
REQ-004 Parameter STAGGER, default 16: cycles between successive channel releases (1..255).
REQ-005 Parameter SYNC_STAGES, default 2: flops in the pll_lock synchroniser (2..4).
REQ-006 Parameter USE_LOCK, default 1: 0 forces the synchronised lock to 1.
REQ-007 clk  input  1  single system clock; all logic on its rising edge.
REQ-008 reset_n  input  1  asynchronous, active-low reset; one clock, reset asynchronous active-low.
REQ-009 pll_lock  input  1  asynchronous PLL lock indication.
REQ-010 sw_reset_req  input  1  synchronous one-cycle software reset request.
REQ-011 cause_clr  input  1  synchronous one-cycle clear of rst_cause.
REQ-012 rst_out  output  NUM_OUT  active-high channel resets; channel k releases before channel k+1.
REQ-013 all_ready  output  1  high only in RUN.
REQ-014 state  output  2  current state: 0 HOLD, 1 WAIT_LOCK, 2 RELEASE, 3 RUN.
REQ-015 rst_cause  output  3  sticky cause bits {sw, lock_loss, por}.

Function
REQ-016 States SHALL be HOLD, WAIT_LOCK, RELEASE and RUN, all registered.
REQ-017 HOLD SHALL last exactly POR_CYCLES cycles from entry, then go to WAIT_LOCK regardless of lock.
REQ-018 pll_lock SHALL pass through SYNC_STAGES flops; lock_s denotes the synchroniser output.
REQ-019 WAIT_LOCK: filter counter increments while lock_s=1, clears when lock_s=0; go to RELEASE on the cycle it reaches LOCK_FILT.
REQ-020 RELEASE: stagger counter runs 0..STAGGER-1; each wrap deasserts the next channel, index 0 first.
REQ-021 rst_out[k] SHALL fall exactly STAGGER*(k+1) cycles after RELEASE entry; the cycle rst_out[NUM_OUT-1] falls, state becomes RUN and all_ready rises.
REQ-022 rst_out SHALL be all ones in HOLD and WAIT_LOCK; released channels stay low until a reset event.
REQ-023 Lock loss: lock_s=0 in RELEASE or RUN -> next edge state=WAIT_LOCK, rst_out all ones, all_ready=0, lock_loss cause set; pin-to-rst_out latency SYNC_STAGES+1 cycles.
REQ-024 sw_reset_req=1 in WAIT_LOCK, RELEASE or RUN -> next edge state=HOLD with full POR_CYCLES reload, rst_out all ones, sw cause set; ignored in HOLD.
REQ-025 sw_reset_req and lock loss in the same cycle: HOLD wins; both cause bits set.
REQ-026 cause_clr clears rst_cause; a cause event in the same cycle wins for its bit.
REQ-027 Counters SHALL saturate or reload only as stated; no wrap-around into a false release.
REQ-028 USE_LOCK=0: WAIT_LOCK lasts exactly LOCK_FILT cycles; lock_loss never set.

Reset
REQ-029 reset_n low SHALL immediately, without a clock edge, force rst_out all ones, all_ready=0, state=HOLD, all counters and synchroniser flops 0, rst_cause=3'b001.
REQ-030 reset_n assertion mid-RELEASE or mid-RUN SHALL behave identically to REQ-029; release restarts HOLD from count 0.

Verification (defaults unless stated)
REQ-031 pll_lock=1 held, reset_n rises at edge 0 -> WAIT_LOCK at 255, RELEASE at 259, rst_out[0..3] fall at 275/291/307/323, all_ready=1 at 323, rst_cause=001.
REQ-032 In RUN, pll_lock low 1 cycle -> rst_out=4'hF 3 cycles later, state=WAIT_LOCK, rst_cause=011; relock -> full stagger release repeats.
REQ-033 pll_lock toggles every 3 cycles in WAIT_LOCK -> never leaves WAIT_LOCK, rst_out stays 4'hF.
REQ-034 sw_reset_req pulse in RUN same cycle as pll_lock loss reaching lock_s -> state=HOLD, rst_cause=111; cause_clr -> 000.
REQ-035 reset_n pulsed low for under one clock period during RELEASE -> rst_out=4'hF asynchronously, rst_cause=001, sequence restarts per REQ-031.
REQ-036 NUM_OUT=1, STAGGER=1, USE_LOCK=0, POR_CYCLES=1 -> rst_out[0] falls and all_ready rises at cycle 6.
